f_fetch_stage: RTL and testbench

// - Fetch stage of the 5-stage MIPS pipeline: owns the PC register and the F/D pipeline register.
// - Drives the instruction-memory address and captures the returned word.
// - Feeds D: D_instr[15:0] goes to the D-stage immediate extender; D_instr and D_pc go to decode/NPC.
// - Raises AdEL on bad fetch addresses; handles stall, exception redirect (req) and eret redirect.

---
 rtl/f_fetch_stage.sv | 95 +++++++++
 tb/tb_f_fetch_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/f_fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory
// address generation, fetch address checking (AdEL) and the F/D pipeline register.
module f_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret_D,
    input  logic [31:0] EPC,
    input  logic        D_npc_sel,
    input  logic [31:0] D_npc,
    input  logic        D_is_branch,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [4:0]  D_exccode,
    output logic        D_bd
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc;
    logic        F_adel;
    logic [31:0] F_instr;
    logic [4:0]  F_exccode;

    assign F_pc        = pc;
    assign i_inst_addr = pc;

    // A faulting fetch becomes a nop carrying AdEL; the PC keeps advancing.
    always_comb begin
        F_adel    = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
        F_instr   = i_inst_rdata;
        F_exccode = EXC_NONE;
        if (F_adel) begin
            F_instr   = '0;
            F_exccode = EXC_ADEL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (req) begin
            pc <= HANDLER_PC;
        end else if (stall) begin
            pc <= pc;
        end else if (eret_D) begin
            pc <= EPC;
        end else if (D_npc_sel) begin
            pc <= D_npc;
        end else begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            D_instr   <= '0;
            D_pc      <= RESET_PC;
            D_exccode <= EXC_NONE;
            D_bd      <= 1'b0;
        end else if (req) begin
            D_instr   <= '0;
            D_pc      <= HANDLER_PC;
            D_exccode <= EXC_NONE;
            D_bd      <= 1'b0;
        end else if (stall) begin
            D_instr   <= D_instr;
            D_pc      <= D_pc;
            D_exccode <= D_exccode;
            D_bd      <= D_bd;
        end else if (eret_D) begin
            // Bubble tagged with EPC so the instruction after eret never executes.
            D_instr   <= '0;
            D_pc      <= EPC;
            D_exccode <= EXC_NONE;
            D_bd      <= 1'b0;
        end else begin
            D_instr   <= F_instr;
            D_pc      <= pc;
            D_exccode <= F_exccode;
            D_bd      <= D_is_branch;
        end
    end

endmodule

// File: tb/tb_f_fetch_stage.sv
// Directed self-checking bench for f_fetch_stage; instruction memory is a
// small address-to-word table so expected D_instr values are known by hand.
module tb_f_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, req, eret_D, D_npc_sel, D_is_branch;
    logic [31:0] EPC, D_npc;
    logic [31:0] i_inst_addr, i_inst_rdata, F_pc, D_instr, D_pc;
    logic [4:0]  D_exccode;
    logic        D_bd;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    // Two fixed words, everything else reads back as {16'hABCD, addr[15:0]}.
    always_comb begin
        if (i_inst_addr == 32'h0000_3000)      i_inst_rdata = 32'h3c01_0001;
        else if (i_inst_addr == 32'h0000_3004) i_inst_rdata = 32'h3421_0002;
        else                                   i_inst_rdata = {16'hABCD, i_inst_addr[15:0]};
    end

    f_fetch_stage #(
        .RESET_PC  (32'h0000_3000),
        .HANDLER_PC(32'h0000_4180),
        .IM_LO     (32'h0000_3000),
        .IM_HI     (32'h0000_6ffc)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .req(req), .eret_D(eret_D),
        .EPC(EPC), .D_npc_sel(D_npc_sel), .D_npc(D_npc), .D_is_branch(D_is_branch),
        .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata), .F_pc(F_pc),
        .D_instr(D_instr), .D_pc(D_pc), .D_exccode(D_exccode), .D_bd(D_bd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [4:0] exc, input logic bd);
        check({tag, "_instr"}, D_instr, instr);
        check({tag, "_pc"}, D_pc, pc);
        check({tag, "_exc"}, {27'd0, D_exccode}, {27'd0, exc});
        check({tag, "_bd"}, {31'd0, D_bd}, {31'd0, bd});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; req = 1'b0; eret_D = 1'b0;
        D_npc_sel = 1'b0; D_is_branch = 1'b0; EPC = '0; D_npc = '0;

        // Reset and straight-line fetch
        tick(); tick();
        check("rst_fpc", F_pc, 32'h3000);
        check("rst_iaddr", i_inst_addr, 32'h3000);
        check_d("rst", 32'h0, 32'h3000, 5'd0, 1'b0);
        reset = 1'b0;
        tick();
        check("seq1_fpc", F_pc, 32'h3004);
        check_d("seq1", 32'h3c01_0001, 32'h3000, 5'd0, 1'b0);
        tick();
        check("seq2_fpc", F_pc, 32'h3008);
        check_d("seq2", 32'h3421_0002, 32'h3004, 5'd0, 1'b0);

        // Stall holds PC and F/D
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_fpc", F_pc, 32'h3008);
            check_d("stall", 32'h3421_0002, 32'h3004, 5'd0, 1'b0);
        end
        stall = 1'b0;
        tick();
        check("unstall_fpc", F_pc, 32'h300c);
        check_d("unstall", 32'hABCD_3008, 32'h3008, 5'd0, 1'b0);
        tick();
        check("adv_fpc", F_pc, 32'h3010);

        // Taken branch: delay slot loaded with bd=1, target fetched next
        D_is_branch = 1'b1; D_npc_sel = 1'b1; D_npc = 32'h3100;
        tick();
        check("br_fpc", F_pc, 32'h3100);
        check_d("br_slot", 32'hABCD_3010, 32'h3010, 5'd0, 1'b1);
        D_is_branch = 1'b0; D_npc_sel = 1'b0;
        tick();
        check("br_tgt_fpc", F_pc, 32'h3104);
        check_d("br_tgt", 32'hABCD_3100, 32'h3100, 5'd0, 1'b0);

        // Stall beats D_npc_sel; redirect taken on first unstalled cycle
        stall = 1'b1; D_npc_sel = 1'b1; D_npc = 32'h3200;
        tick();
        check("stnpc_fpc", F_pc, 32'h3104);
        check("stnpc_dpc", D_pc, 32'h3100);
        stall = 1'b0;
        tick();
        check("stnpc2_fpc", F_pc, 32'h3200);
        check_d("stnpc2", 32'hABCD_3104, 32'h3104, 5'd0, 1'b0);
        D_npc_sel = 1'b0;

        // eret to a misaligned EPC
        eret_D = 1'b1; EPC = 32'h3001;
        tick();
        check("eret_fpc", F_pc, 32'h3001);
        check_d("eret", 32'h0, 32'h3001, 5'd0, 1'b0);
        eret_D = 1'b0;
        tick();
        check("adel_mis_fpc", F_pc, 32'h3005);
        check_d("adel_mis", 32'h0, 32'h3001, 5'd4, 1'b0);

        // req beats stall; bubble clears exccode and bd
        req = 1'b1; stall = 1'b1; D_is_branch = 1'b1;
        tick();
        check("req_fpc", F_pc, 32'h4180);
        check_d("req", 32'h0, 32'h4180, 5'd0, 1'b0);
        req = 1'b0; stall = 1'b0; D_is_branch = 1'b0;

        // Upper boundary of instruction memory
        D_npc_sel = 1'b1; D_npc = 32'h6ffc;
        tick();
        check("hi_fpc", F_pc, 32'h6ffc);
        check_d("hi_pre", 32'hABCD_4180, 32'h4180, 5'd0, 1'b0);
        D_npc_sel = 1'b0;
        tick();
        check("hi_ok_fpc", F_pc, 32'h7000);
        check_d("hi_ok", 32'hABCD_6ffc, 32'h6ffc, 5'd0, 1'b0);
        tick();
        check("hi_bad_fpc", F_pc, 32'h7004);
        check_d("hi_bad", 32'h0, 32'h7000, 5'd4, 1'b0);

        // Lower boundary
        eret_D = 1'b1; EPC = 32'h2ffc;
        tick();
        eret_D = 1'b0;
        tick();
        check("lo_fpc", F_pc, 32'h3000);
        check_d("lo_bad", 32'h0, 32'h2ffc, 5'd4, 1'b0);

        // PC wrap at the top of the address space
        eret_D = 1'b1; EPC = 32'hffff_fffc;
        tick();
        eret_D = 1'b0;
        tick();
        check("wrap_fpc", F_pc, 32'h0000_0000);
        check_d("wrap", 32'h0, 32'hffff_fffc, 5'd4, 1'b0);

        // Reset mid-operation overrides req/eret/branch
        reset = 1'b1; req = 1'b1; eret_D = 1'b1; D_npc_sel = 1'b1; D_is_branch = 1'b1;
        tick();
        check("rst2_fpc", F_pc, 32'h3000);
        check_d("rst2", 32'h0, 32'h3000, 5'd0, 1'b0);
        tick();
        check("rst3_fpc", F_pc, 32'h3000);
        reset = 1'b0; req = 1'b0; eret_D = 1'b0; D_npc_sel = 1'b0; D_is_branch = 1'b0;
        tick();
        check("post_rst_fpc", F_pc, 32'h3004);
        check_d("post_rst", 32'h3c01_0001, 32'h3000, 5'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
